icache_refill_bridge: RTL and testbench
=======================================

# icache_refill_bridge

Memory-side responder for the instruction-cache refill interface. Accepts one refill request at a time from the ICache (`ReadMAble`/`ReadMAddr`/`ReadMlen`/`ReadMsize`/`ReadMBurstTy`), issues it as an AXI4 read address transaction, and returns each R-channel beat to the ICache as `MemoryAble`/`MemoryAddr`/`MemoryDate`, flagging the final beat with `MemoryBrustAble`. It sits between the ICache and the core AXI master port. It never writes memory.

## Interface
- `AXIID`, 4'd0: fixed ARID driven on every request.
- `Clk` in 1: clock; all logic is on the rising edge.
- `Rest` in 1: reset, synchronous, active-low.
- `ReadMAble` in 1: refill request valid (level).
- `ReadMAddr` in 32: start byte address.
- `ReadMlen` in 8: AXI length, beats-1.
- `ReadMsize` in 3: AXI size; legal values 0..2.
- `ReadMBurstTy` in 2: AXI burst type; 01 INCR, 10 WRAP.
- `RefillFlush` in 1: discard the current refill.
- `RefillBusy` out 1: bridge not IDLE.
- `MemoryAble` out 1: beat valid to ICache.
- `MemoryBrustAble` out 1: final beat of burst.
- `MemoryAddr` out 32: byte address of this beat.
- `MemoryDate` out 32: beat data.
- `RefillErr` out 1: sticky error flag.
- `ArValid` out 1, `ArReady` in 1, `ArAddr` out 32, `ArLen` out 8, `ArSize` out 3, `ArBurst` out 2, `ArId` out 4: AXI AR channel.
- `RValid` in 1, `RReady` out 1, `RData` in 32, `RResp` in 2, `RLast` in 1: AXI R channel (RID ignored).

## Operation
- States: IDLE, ADDR, DATA, DONE.
- IDLE: if `ReadMAble`=1, capture addr/len/size/burst and go to ADDR. Otherwise stay in IDLE.
- ADDR: `ArValid`=1 with the captured fields. When `ArReady`=1, go to DATA. `ArValid` must not drop before the handshake completes.
- DATA: `RReady`=1. Each cycle with `RValid&RReady` counts as one beat.
  - The beat counter increments.
  - The beat address advances:
    - INCR: addr + (1<<size).
    - WRAP: total = (len+1)<<size; next = (addr & ~(total-1)) | ((addr+(1<<size)) & (total-1)).
  - The final beat is the beat where count==len. Go to DONE on that beat.
- DONE: one cycle, then IDLE. A new request can be captured only in IDLE, so the ICache must deassert `ReadMAble` by the DONE cycle or a second refill is issued.
- Error conditions set `RefillErr`, which is cleared only by reset:
  - `RResp`!=00.
  - `RLast` disagrees with count==len.
  - `ReadMsize`>2 at capture. The size is then clamped to 2.
  - `ReadMBurstTy` other than INCR/WRAP at capture. The burst is then issued as INCR.
- The burst length is governed by `ReadMlen`, not `RLast`. If `RLast` arrives early, the bridge keeps accepting beats until count==len.
- `RefillFlush`=1 in any non-IDLE state:
  - Marks the transaction discarded.
  - The AXI transfer still completes: AR is held, and all beats are drained.
  - `MemoryAble` and `MemoryBrustAble` stay 0 for the rest of that transaction.
  - The discarded mark clears on entry to IDLE.
  - Flush in IDLE has no effect.

## Timing
- Reset values:
  - State is IDLE.
  - `ArValid`, `RReady`, `MemoryAble`, `MemoryBrustAble`, `RefillErr`, `RefillBusy` are 0.
  - `ArAddr`, `ArLen`, `ArSize`, `ArBurst`, `MemoryAddr`, `MemoryDate` are 0.
  - `ArId`=`AXIID`.
- Reset mid-transaction returns the bridge to IDLE immediately. The external AXI slave must be reset alongside it.
- Request latency: `ReadMAble` sampled at edge N gives `ArValid`=1 from cycle N+1.
- Beat latency: one registered stage. A beat accepted at edge M gives `MemoryAble`=1 during cycle M+1, with `MemoryAddr`/`MemoryDate` of that beat. `MemoryAble` is a single-cycle pulse per beat.
- `MemoryBrustAble` is high only with the last beat's `MemoryAble`. DONE coincides with that cycle.
- `RefillBusy` is high in ADDR, DATA, and DONE.
- With zero-wait AXI, a len=7 refill occupies 1 ADDR cycle, 8 DATA cycles, and 1 DONE cycle.

## Configuration
- `REFILL_WRAP_EN` defined: WRAP bursts are supported as described in Operation (critical-word-first refills).
- `REFILL_WRAP_EN` undefined:
  - `ArBurst` is always INCR.
  - The captured address is aligned down to a (len+1)<<size boundary before issue.
  - Beat addresses are plain INCR.
  - A WRAP request does not set `RefillErr`.

## Test plan
- INCR refill: addr 0x1C000040, len 7, size 2, zero-wait AXI, data 0xA0..0xA7.
  - Eight `MemoryAble` pulses at addrs 0x..40, 0x..44, … 0x..5C.
  - `MemoryBrustAble` only with 0xA7.
  - `RefillErr`=0.
- WRAP refill (`REFILL_WRAP_EN` defined): addr 0x1C000058, len 7, size 2.
  - Beat addrs 58, 5C, 40, 44, 48, 4C, 50, 54.
- AR backpressure: `ArReady` low for 5 cycles.
  - `ArValid` and the AR fields are stable for 6 cycles.
  - No `RReady` before the handshake.
- R stalls: `RValid` toggles 1,0,0,1,… through the burst.
  - Exactly len+1 `MemoryAble` pulses, in order, each one cycle after its accepted beat.
- Error: `RResp`=10 on beat 3, and `RLast` asserted on beat 5 of a len=7 burst.
  - `RefillErr` goes to 1 and stays 1.
  - The bridge still waits for 8 beats before IDLE.
- Flush: `RefillFlush` pulsed during beat 2.
  - No further `MemoryAble`.
  - Beats 3–7 are still drained with `RReady`=1.
  - `RefillBusy` falls after beat 7; the next request is accepted normally.

Source files
------------

// File: rtl/icache_refill_bridge_if.sv
// AXI4 read-only channel bundle (AR + R) between the icache refill bridge and memory.
interface icache_refill_bridge_if;
  logic        ArValid;
  logic        ArReady;
  logic [31:0] ArAddr;
  logic [7:0]  ArLen;
  logic [2:0]  ArSize;
  logic [1:0]  ArBurst;
  logic [3:0]  ArId;
  logic        RValid;
  logic        RReady;
  logic [31:0] RData;
  logic [1:0]  RResp;
  logic        RLast;

  modport master (
    output ArValid, ArAddr, ArLen, ArSize, ArBurst, ArId, RReady,
    input  ArReady, RValid, RData, RResp, RLast
  );

  modport slave (
    input  ArValid, ArAddr, ArLen, ArSize, ArBurst, ArId, RReady,
    output ArReady, RValid, RData, RResp, RLast
  );
endinterface

// File: rtl/icache_refill_bridge.sv
// ICache refill responder: one AXI4 read burst per refill, beats returned one cycle after acceptance.
// Define REFILL_WRAP_EN to issue WRAP bursts; otherwise every refill is an aligned INCR burst.
module icache_refill_bridge #(
  parameter logic [3:0] AXIID = 4'd0
) (
  input  logic        Clk,
  input  logic        Rest,
  input  logic        ReadMAble,
  input  logic [31:0] ReadMAddr,
  input  logic [7:0]  ReadMlen,
  input  logic [2:0]  ReadMsize,
  input  logic [1:0]  ReadMBurstTy,
  input  logic        RefillFlush,
  output logic        RefillBusy,
  output logic        MemoryAble,
  output logic        MemoryBrustAble,
  output logic [31:0] MemoryAddr,
  output logic [31:0] MemoryDate,
  output logic        RefillErr,
  output logic [1:0]  dbg_state_o,
  icache_refill_bridge_if.master axi
);

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] ar_addr_q, ar_addr_d;
  logic [31:0] beat_addr_q, beat_addr_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  burst_q, burst_d;
  logic        discard_q, discard_d;
  logic        err_q, err_d;
  logic        mem_able_q, mem_able_d;
  logic        mem_last_q, mem_last_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_data_q, mem_data_d;

  logic        capture, beat, last_beat, burst_ok, deliver;
  logic [2:0]  req_size;
  logic [1:0]  req_burst;
  logic [31:0] req_addr, step, next_addr;

  // Handshakes follow AXI valid/ready: a transfer happens on an edge where both are high.
  // ArValid and its fields hold steady in ADDR until ArReady; RReady is high for all of DATA.
  assign capture   = (state_q == S_IDLE) && ReadMAble;
  assign beat      = (state_q == S_DATA) && axi.RValid;
  assign last_beat = (cnt_q == len_q);
  assign burst_ok  = (ReadMBurstTy == BURST_INCR) || (ReadMBurstTy == BURST_WRAP);
  assign req_size  = (ReadMsize > 3'd2) ? 3'd2 : ReadMsize;
  assign step      = 32'd1 << size_q;
  assign deliver   = beat && !discard_q && !RefillFlush;

`ifdef REFILL_WRAP_EN
  logic [31:0] wrap_mask;
  assign wrap_mask = ((32'({24'd0, len_q}) + 32'd1) << size_q) - 32'd1;
  assign req_burst = burst_ok ? ReadMBurstTy : BURST_INCR;
  assign req_addr  = ReadMAddr;
  assign next_addr = (burst_q == BURST_WRAP)
                   ? ((beat_addr_q & ~wrap_mask) | ((beat_addr_q + step) & wrap_mask))
                   : (beat_addr_q + step);
`else
  logic [31:0] req_mask;
  // Without WRAP support the burst starts at the naturally aligned block holding the request.
  assign req_mask  = ((32'({24'd0, ReadMlen}) + 32'd1) << req_size) - 32'd1;
  assign req_burst = BURST_INCR;
  assign req_addr  = ReadMAddr & ~req_mask;
  assign next_addr = beat_addr_q + step;
`endif

  always_ff @(posedge Clk) begin
    if (!Rest) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ReadMAble) state_d = S_ADDR;
      S_ADDR:  if (axi.ArReady) state_d = S_DATA;
      S_DATA:  if (beat && last_beat) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    axi.ArValid = (state_q == S_ADDR);
    axi.RReady  = (state_q == S_DATA);
    RefillBusy  = (state_q != S_IDLE);
  end

  always_comb begin
    ar_addr_d   = ar_addr_q;
    beat_addr_d = beat_addr_q;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    mem_able_d  = 1'b0;
    mem_last_d  = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    discard_d   = discard_q;
    if (capture) begin
      ar_addr_d   = req_addr;
      beat_addr_d = req_addr;
      len_d       = ReadMlen;
      size_d      = req_size;
      burst_d     = req_burst;
      cnt_d       = 8'd0;
      if ((ReadMsize > 3'd2) || !burst_ok) err_d = 1'b1;
    end
    if (beat) begin
      cnt_d       = cnt_q + 8'd1;
      beat_addr_d = next_addr;
      mem_addr_d  = beat_addr_q;
      mem_data_d  = axi.RData;
      mem_able_d  = deliver;
      mem_last_d  = deliver && last_beat;
      // Length comes from the request; RLast is only cross-checked.
      if ((axi.RResp != 2'b00) || (axi.RLast != last_beat)) err_d = 1'b1;
    end
    if (state_d == S_IDLE)                       discard_d = 1'b0;
    else if ((state_q != S_IDLE) && RefillFlush) discard_d = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (!Rest) begin
      ar_addr_q   <= 32'd0;
      beat_addr_q <= 32'd0;
      len_q       <= 8'd0;
      size_q      <= 3'd0;
      burst_q     <= 2'd0;
      cnt_q       <= 8'd0;
      err_q       <= 1'b0;
      mem_able_q  <= 1'b0;
      mem_last_q  <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_data_q  <= 32'd0;
      discard_q   <= 1'b0;
    end else begin
      ar_addr_q   <= ar_addr_d;
      beat_addr_q <= beat_addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      mem_able_q  <= mem_able_d;
      mem_last_q  <= mem_last_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      discard_q   <= discard_d;
    end
  end

  assign axi.ArAddr      = ar_addr_q;
  assign axi.ArLen       = len_q;
  assign axi.ArSize      = size_q;
  assign axi.ArBurst     = burst_q;
  assign axi.ArId        = AXIID;
  assign MemoryAble      = mem_able_q;
  assign MemoryBrustAble = mem_last_q;
  assign MemoryAddr      = mem_addr_q;
  assign MemoryDate      = mem_data_q;
  assign RefillErr       = err_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_icache_refill_bridge.sv
// Self-checking bench for icache_refill_bridge: AXI slave driver, spec-level address model, beat scoreboard.
module tb_icache_refill_bridge;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ReadMAble = 1'b0, RefillFlush = 1'b0;
  logic [31:0] ReadMAddr = '0;
  logic [7:0]  ReadMlen = '0;
  logic [2:0]  ReadMsize = '0;
  logic [1:0]  ReadMBurstTy = '0;
  logic        RefillBusy, MemoryAble, MemoryBrustAble, RefillErr;
  logic [31:0] MemoryAddr, MemoryDate;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  icache_refill_bridge_if axi_if ();

  icache_refill_bridge #(.AXIID(4'd0)) dut (
    .Clk(clk), .Rest(rst_n),
    .ReadMAble(ReadMAble), .ReadMAddr(ReadMAddr), .ReadMlen(ReadMlen),
    .ReadMsize(ReadMsize), .ReadMBurstTy(ReadMBurstTy), .RefillFlush(RefillFlush),
    .RefillBusy(RefillBusy), .MemoryAble(MemoryAble), .MemoryBrustAble(MemoryBrustAble),
    .MemoryAddr(MemoryAddr), .MemoryDate(MemoryDate), .RefillErr(RefillErr),
    .dbg_state_o(dbg_state), .axi(axi_if)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  // scoreboard state: {last, addr, data}
  logic [64:0] exp_q[$];
  logic [64:0] obs_q[$];
  logic [31:0] sent_q[$];
  int          acc_cyc_q[$];
  int          obs_cyc_q[$];
  int          busy_cycles, ar_cycles;
  bit          ar_unstable, rready_early, req_late, done_bad, timeout;
  logic [31:0] cap_ar_addr;
  logic [7:0]  cap_ar_len;
  logic [2:0]  cap_ar_size;
  logic [1:0]  cap_ar_burst;

  // reference model, written from the refill rules
  function automatic logic [2:0] m_size(input logic [2:0] s);
    return (s > 3'd2) ? 3'd2 : s;
  endfunction

  function automatic logic [31:0] m_total(input logic [7:0] len, input logic [2:0] s);
    return (32'(len) + 32'd1) * (32'd1 << m_size(s));
  endfunction

  function automatic bit m_wrap(input logic [1:0] b);
`ifdef REFILL_WRAP_EN
    return b == 2'b10;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_ar_addr(input logic [31:0] a, input logic [7:0] len, input logic [2:0] s);
`ifdef REFILL_WRAP_EN
    return a;
`else
    return a - (a % m_total(len, s));
`endif
  endfunction

  function automatic logic [1:0] m_ar_burst(input logic [1:0] b);
    return m_wrap(b) ? 2'b10 : 2'b01;
  endfunction

  function automatic bit m_err(input logic [2:0] s, input logic [1:0] b);
    return (s > 3'd2) || !((b == 2'b01) || (b == 2'b10));
  endfunction

  function automatic logic [31:0] m_beat_addr(input logic [31:0] a, input logic [7:0] len,
                                              input logic [2:0] s, input logic [1:0] b, input int k);
    logic [31:0] total, base, step;
    total = m_total(len, s);
    step  = 32'd1 << m_size(s);
    base  = a - (a % total);
    if (m_wrap(b)) return base + (((a - base) + 32'(k) * step) % total);
    return m_ar_addr(a, len, s) + 32'(k) * step;
  endfunction

  task automatic build_exp(input logic [31:0] a, input logic [7:0] len, input logic [2:0] s,
                           input logic [1:0] b, input int n_deliver);
    exp_q.delete();
    for (int k = 0; k < n_deliver; k++)
      exp_q.push_back({(k == int'(len)), m_beat_addr(a, len, s, b, k),
                       (k < sent_q.size()) ? sent_q[k] : 32'd0});
  endtask

  // driver tasks
  task automatic idle_inputs();
    ReadMAble = 1'b0; RefillFlush = 1'b0;
    axi_if.ArReady = 1'b0; axi_if.RValid = 1'b0; axi_if.RData = '0;
    axi_if.RResp = 2'b00; axi_if.RLast = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
  endtask

  // Issues one refill and plays the AXI slave until the bridge is idle again.
  // stall_mode: 0 zero-wait, 1 RValid 1,0,0 repeating, 2 random. data_base < 0 gives random data.
  task automatic do_refill(input logic [31:0] a, input logic [7:0] len, input logic [2:0] s,
                           input logic [1:0] b, input int ar_wait, input int stall_mode,
                           input int resp_beat, input int rlast_beat, input int flush_beat,
                           input int data_base);
    int beats, ar_cnt, rv_ph, n;
    bit ar_done, ar_seen;
    beats = 0; ar_cnt = 0; rv_ph = 0; n = 0; ar_done = 0; ar_seen = 0;
    obs_q.delete(); sent_q.delete(); acc_cyc_q.delete(); obs_cyc_q.delete();
    busy_cycles = 0; ar_cycles = 0;
    ar_unstable = 0; rready_early = 0; done_bad = 0; timeout = 0;
    ReadMAble = 1'b1; ReadMAddr = a; ReadMlen = len; ReadMsize = s; ReadMBurstTy = b;
    @(posedge clk); #1;
    ReadMAble = 1'b0; ReadMAddr = $urandom; ReadMlen = 8'($urandom); ReadMsize = 3'($urandom);
    req_late = !axi_if.ArValid;
    while (1) begin
      if (n > 2000) begin timeout = 1; break; end
      if (!RefillBusy) break;
      busy_cycles++;
      if (MemoryAble) begin
        obs_q.push_back({MemoryBrustAble, MemoryAddr, MemoryDate});
        obs_cyc_q.push_back(cyc);
      end
      if (MemoryBrustAble && (!MemoryAble || dbg_state != 2'd3)) done_bad = 1;
      if (axi_if.ArValid) begin
        ar_cycles++;
        if (!ar_seen) begin
          ar_seen = 1;
          cap_ar_addr = axi_if.ArAddr; cap_ar_len = axi_if.ArLen;
          cap_ar_size = axi_if.ArSize; cap_ar_burst = axi_if.ArBurst;
        end else if ({axi_if.ArAddr, axi_if.ArLen, axi_if.ArSize, axi_if.ArBurst} !==
                     {cap_ar_addr, cap_ar_len, cap_ar_size, cap_ar_burst}) ar_unstable = 1;
      end
      if (axi_if.RReady && !ar_done) rready_early = 1;
      axi_if.ArReady = axi_if.ArValid && (ar_cnt >= ar_wait);
      if (axi_if.ArValid) ar_cnt++;
      if (beats > int'(len)) axi_if.RValid = 1'b0;
      else if (stall_mode == 0) axi_if.RValid = 1'b1;
      else if (stall_mode == 1) axi_if.RValid = (rv_ph % 3 == 0);
      else axi_if.RValid = 1'($urandom_range(0, 1));
      if (axi_if.RReady) rv_ph++;
      axi_if.RData  = (data_base >= 0) ? 32'(data_base + beats) : $urandom;
      axi_if.RResp  = (beats == resp_beat) ? 2'b10 : 2'b00;
      axi_if.RLast  = (beats == rlast_beat);
      RefillFlush   = (beats == flush_beat) && axi_if.RValid && axi_if.RReady;
      if (axi_if.ArValid && axi_if.ArReady) ar_done = 1;
      if (axi_if.RValid && axi_if.RReady) begin
        sent_q.push_back(axi_if.RData);
        acc_cyc_q.push_back(cyc);
        beats++;
      end
      @(posedge clk); #1;
      n++;
    end
    idle_inputs();
  endtask

  // tests
  task automatic test_reset();
    apply_reset();
    checks++; if ({axi_if.ArValid, axi_if.RReady, MemoryAble, MemoryBrustAble, RefillErr, RefillBusy} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 000000", {axi_if.ArValid, axi_if.RReady, MemoryAble, MemoryBrustAble, RefillErr, RefillBusy}); end
    checks++; if ({axi_if.ArAddr, axi_if.ArLen, axi_if.ArSize, axi_if.ArBurst} !== 45'd0) begin
      errors++; $display("FAIL reset_ar got %h/%h/%h/%h exp 0", axi_if.ArAddr, axi_if.ArLen, axi_if.ArSize, axi_if.ArBurst); end
    checks++; if ({MemoryAddr, MemoryDate} !== 64'd0) begin
      errors++; $display("FAIL reset_mem got %h/%h exp 0", MemoryAddr, MemoryDate); end
    checks++; if (axi_if.ArId !== 4'd0) begin
      errors++; $display("FAIL reset_arid got %h exp 0", axi_if.ArId); end
    checks++; if (dbg_state !== 2'd0) begin
      errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    ReadMAble = 1'b1; ReadMAddr = 32'h1C00_0040; ReadMlen = 8'd7; ReadMsize = 3'd2; ReadMBurstTy = 2'b01;
    @(posedge clk); #1;
    ReadMAble = 1'b0;
    checks++; if ({axi_if.ArValid, axi_if.ArAddr} !== {1'b1, 32'h1C00_0040}) begin
      errors++; $display("FAIL req_latency got %b/%h exp 1/1c000040", axi_if.ArValid, axi_if.ArAddr); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if ({axi_if.ArValid, RefillBusy, axi_if.ArAddr} !== 34'd0) begin
      errors++; $display("FAIL mid_reset got %b/%b/%h exp 0/0/0", axi_if.ArValid, RefillBusy, axi_if.ArAddr); end
  endtask

  task automatic test_incr();
    apply_reset();
    do_refill(32'h1C00_0040, 8'd7, 3'd2, 2'b01, 0, 0, -1, 7, -1, 32'hA0);
    build_exp(32'h1C00_0040, 8'd7, 3'd2, 2'b01, 8);
    checks++; if (obs_q.size() != exp_q.size() || timeout) begin
      errors++; $display("FAIL incr_count got %0d exp %0d timeout %0d", obs_q.size(), exp_q.size(), timeout); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL incr_beat%0d got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (busy_cycles != 10 || ar_cycles != 1 || req_late) begin
      errors++; $display("FAIL incr_timing got busy %0d ar %0d late %0d exp 10 1 0", busy_cycles, ar_cycles, req_late); end
    checks++; if (done_bad || RefillErr !== 1'b0) begin
      errors++; $display("FAIL incr_done_err got done_bad %0d err %b exp 0 0", done_bad, RefillErr); end
  endtask

  task automatic test_wrap();
    apply_reset();
    do_refill(32'h1C00_0058, 8'd7, 3'd2, 2'b10, 0, 0, -1, 7, -1, -1);
    build_exp(32'h1C00_0058, 8'd7, 3'd2, 2'b10, 8);
    checks++; if (obs_q.size() != exp_q.size() || timeout) begin
      errors++; $display("FAIL wrap_count got %0d exp %0d timeout %0d", obs_q.size(), exp_q.size(), timeout); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL wrap_beat%0d got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if ({cap_ar_addr, cap_ar_burst, RefillErr} !== {m_ar_addr(32'h1C00_0058, 8'd7, 3'd2), m_ar_burst(2'b10), 1'b0}) begin
      errors++; $display("FAIL wrap_ar got %h/%b/%b exp %h/%b/0", cap_ar_addr, cap_ar_burst, RefillErr,
                          m_ar_addr(32'h1C00_0058, 8'd7, 3'd2), m_ar_burst(2'b10)); end
  endtask

  task automatic test_ar_backpressure();
    apply_reset();
    do_refill(32'h0000_1230, 8'd3, 3'd2, 2'b01, 5, 0, -1, 3, -1, -1);
    build_exp(32'h0000_1230, 8'd3, 3'd2, 2'b01, 4);
    checks++; if (ar_cycles != 6 || ar_unstable || rready_early || timeout) begin
      errors++; $display("FAIL ar_hold got cycles %0d unstable %0d early_rready %0d exp 6 0 0", ar_cycles, ar_unstable, rready_early); end
    checks++; if ({cap_ar_addr, cap_ar_len, cap_ar_size, cap_ar_burst} !== {m_ar_addr(32'h1230, 8'd3, 3'd2), 8'd3, 3'd2, 2'b01}) begin
      errors++; $display("FAIL ar_fields got %h/%h/%h/%b", cap_ar_addr, cap_ar_len, cap_ar_size, cap_ar_burst); end
    checks++; if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL ar_bp_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL ar_bp_beat%0d got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_r_stalls();
    apply_reset();
    do_refill(32'h8000_0100, 8'd7, 3'd2, 2'b01, 1, 1, -1, 7, -1, -1);
    build_exp(32'h8000_0100, 8'd7, 3'd2, 2'b01, 8);
    checks++; if (obs_q.size() != exp_q.size() || timeout) begin
      errors++; $display("FAIL stall_count got %0d exp %0d timeout %0d", obs_q.size(), exp_q.size(), timeout); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++; if (obs_q[i] !== exp_q[i] || obs_cyc_q[i] != acc_cyc_q[i] + 1) begin
        errors++; $display("FAIL stall_beat%0d got %h @%0d exp %h @%0d", i, obs_q[i], obs_cyc_q[i], exp_q[i], acc_cyc_q[i] + 1); end
    end
  endtask

  task automatic test_error();
    apply_reset();
    do_refill(32'h0000_4000, 8'd7, 3'd2, 2'b01, 0, 0, 3, 5, -1, -1);
    build_exp(32'h0000_4000, 8'd7, 3'd2, 2'b01, 8);
    checks++; if (sent_q.size() != 8 || obs_q.size() != 8 || timeout) begin
      errors++; $display("FAIL err_beats got sent %0d seen %0d exp 8 8", sent_q.size(), obs_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL err_beat%0d got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (RefillErr !== 1'b1) begin
      errors++; $display("FAIL err_set got %b exp 1", RefillErr); end
    repeat (4) begin @(posedge clk); #1; end
    checks++; if ({RefillErr, RefillBusy} !== 2'b10) begin
      errors++; $display("FAIL err_sticky got err %b busy %b exp 1 0", RefillErr, RefillBusy); end
  endtask

  task automatic test_flush();
    apply_reset();
    do_refill(32'h0000_2000, 8'd7, 3'd2, 2'b01, 0, 0, -1, 7, 2, -1);
    build_exp(32'h0000_2000, 8'd7, 3'd2, 2'b01, 2);
    checks++; if (obs_q.size() != 2 || sent_q.size() != 8 || timeout || RefillBusy !== 1'b0) begin
      errors++; $display("FAIL flush_drain got seen %0d sent %0d busy %b exp 2 8 0", obs_q.size(), sent_q.size(), RefillBusy); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL flush_beat%0d got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    do_refill(32'h0000_3010, 8'd3, 3'd2, 2'b01, 0, 0, -1, 3, -1, -1);
    build_exp(32'h0000_3010, 8'd3, 3'd2, 2'b01, 4);
    checks++; if (obs_q.size() != exp_q.size() || timeout) begin
      errors++; $display("FAIL flush_next_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL flush_next_beat%0d got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [7:0]  len;
    logic [2:0]  s;
    logic [1:0]  b;
    for (int it = 0; it < 10; it++) begin
      apply_reset();
      a   = $urandom;
      len = 8'((1 << $urandom_range(0, 4)) - 1);
      s   = 3'($urandom_range(0, 3));
      b   = 2'($urandom_range(0, 3));
      do_refill(a, len, s, b, $urandom_range(0, 3), 2, -1, int'(len), -1, -1);
      build_exp(a, len, s, b, int'(len) + 1);
      checks++; if (obs_q.size() != exp_q.size() || timeout) begin
        errors++; $display("FAIL rand%0d_count got %0d exp %0d", it, obs_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
        checks++; if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rand%0d_beat%0d got %h exp %h", it, i, obs_q[i], exp_q[i]); end
      end
      checks++; if ({RefillErr, cap_ar_addr, cap_ar_size, cap_ar_burst} !==
                    {m_err(s, b), m_ar_addr(a, len, s), m_size(s), m_ar_burst(b)}) begin
        errors++; $display("FAIL rand%0d_ar got err %b %h/%h/%b exp err %b %h/%h/%b", it, RefillErr, cap_ar_addr,
                            cap_ar_size, cap_ar_burst, m_err(s, b), m_ar_addr(a, len, s), m_size(s), m_ar_burst(b)); end
    end
  endtask

  initial begin
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_incr();
    test_wrap();
    test_ar_backpressure();
    test_r_stalls();
    test_error();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
